sparse_vec_encoder: RTL and testbench
=====================================

// Module: sparse_vec_encoder
// PURPOSE
//  Streaming compressor producing the dual-index sparse format consumed by the FC sparse dot-product stage.
//  - Input: one dense vector of VEC_LEN signed elements (activations or weights).
//  - Output: packed stream of the nonzero elements, each tagged with its dense position.
//  - Output: VEC_LEN-bit occupancy bitmap and the nonzero count.
//  - Sits between the layer memory reader and the index-AND / MAC stage.
// PARAMETERS
//  DATA_W   9    element width, two's complement (use 2 for ternary weights)
//  VEC_LEN  128  elements per vector
//  IDX_W    7    position width, $clog2(VEC_LEN)
//  CNT_W    8    count width, $clog2(VEC_LEN+1)
// PORTS
//  clk        in   1        clock; all logic on posedge
//  reset      in   1        synchronous, active-high
//  start      in   1        begin new vector; sampled only in IDLE
//  in_valid   in   1        dense element valid
//  in_data    in   DATA_W   dense element, signed
//  in_ready   out  1        encoder accepts in_data this cycle
//  out_valid  out  1        packed nonzero element valid
//  out_data   out  DATA_W   nonzero element, signed
//  out_pos    out  IDX_W    dense position of out_data
//  out_ready  in   1        downstream accepts out_data
//  index_map  out  VEC_LEN  bit p = 1 iff element p != 0
//  nz_count   out  CNT_W    number of nonzero elements
//  busy       out  1        high in COLLECT and DRAIN
//  done       out  1        one-cycle pulse; index_map and nz_count are final
// BEHAVIOUR
//  Reset:
//  - state=IDLE; pos=0.
//  - index_map=0, nz_count=0, out_valid=0, out_data=0, out_pos=0, done=0.
//  - Reset mid-vector aborts the vector; partial outputs are discarded, no done pulse.
//  FSM IDLE -> COLLECT -> DRAIN -> DONE -> IDLE:
//  - IDLE: start=1 -> COLLECT; clear index_map, nz_count, pos. start outside IDLE is ignored.
//  - COLLECT: in_ready = !out_valid || out_ready.
//    On accept (in_valid && in_ready):
//    - index_map[pos] <= (in_data != 0).
//    - If in_data != 0: out_data <= in_data, out_pos <= pos, out_valid <= 1, nz_count <= nz_count+1.
//    - pos <= pos+1.
//    - Accept at pos == VEC_LEN-1 -> DRAIN; pos does not wrap.
//  - DRAIN: in_ready=0. Leave for DONE once out_valid==0, or when out_valid && out_ready this cycle.
//  - DONE: done=1 for exactly one cycle -> IDLE.
//  Output register:
//  - Single-entry output register.
//  - out_valid is cleared on out_valid && out_ready unless reloaded in the same cycle.
//  - Simultaneous drain + reload is legal and gives full throughput: 1 element/cycle with out_ready=1.
//  - out_data and out_pos hold stable while out_valid && !out_ready.
//  Ordering and latency:
//  - Elements are emitted in ascending out_pos order.
//  - A nonzero accepted in cycle t has out_valid=1 in cycle t+1.
//  Zero and full cases:
//  - Zero elements produce no output beat.
//  - All-zero vector: no out_valid; done is still pulsed; nz_count=0.
//  - Full-dense vector: nz_count=VEC_LEN; CNT_W must hold VEC_LEN.
//  Hold:
//  - index_map and nz_count hold from done until the next accepted start.
//  - Consumer rank of position p = popcount(index_map[p:0]).
// TESTING
//  - Reset mid-COLLECT after 50 elements -> all outputs 0, state IDLE, no done pulse.
//  - Dense 1..128, out_ready=1 -> 128 beats, out_pos 0..127, nz_count=128, done 2 cycles after last accept.
//  - All-zero vector -> no out_valid, index_map=0, nz_count=0, done pulsed once.
//  - Element p = p odd ? -3 : 0 -> 64 beats of -3 at odd positions, index_map=128'hAAAA...A.
//  - Random in_valid/out_ready stalls -> no lost or duplicated beats; out_data/out_pos stable during stall.
//  - start held high throughout -> second vector begins only from IDLE after done.

Source files
------------

// File: rtl/sparse_vec_encoder.sv
// Streaming dense-to-sparse encoder: emits the nonzero elements of one dense vector
// tagged with their positions, and builds an occupancy bitmap plus a nonzero count.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 begin a new vector (taken only in IDLE)
//   in_valid/in_data      dense element input, in_ready = accept this cycle
//   out_valid/out_data    packed nonzero element, out_pos = its dense position,
//   out_pos/out_ready     out_ready = downstream accepts
//   index_map, nz_count   occupancy bitmap and nonzero count (final when done)
//   busy, done            busy in COLLECT/DRAIN, done pulses one cycle at the end
module sparse_vec_encoder #(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned VEC_LEN = 128,
  parameter int unsigned IDX_W   = $clog2(VEC_LEN),
  parameter int unsigned CNT_W   = $clog2(VEC_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic [IDX_W-1:0]   out_pos,
  input  logic               out_ready,
  output logic [VEC_LEN-1:0] index_map,
  output logic [CNT_W-1:0]   nz_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] pos;
  logic             accept;
  logic             beat;
  logic             last;
  logic             nonzero;

  // The output register frees up in the same cycle it drains, so a reload can overlap.
  assign in_ready = (state == COLLECT) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign beat     = out_valid && out_ready;
  assign last     = (pos == IDX_W'(VEC_LEN - 1));
  assign nonzero  = (in_data != '0);

  // State register; busy/done are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == COLLECT) || (state_next == DRAIN);
      done  <= (state_next == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (accept && last) state_next = DRAIN;
      // Finish once the last held beat (if any) transfers.
      DRAIN:   if (!out_valid || out_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position counter, bitmap, count and single-entry output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos       <= '0;
      index_map <= '0;
      nz_count  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_pos   <= '0;
    end else begin
      if ((state == IDLE) && start) begin
        pos       <= '0;
        index_map <= '0;
        nz_count  <= '0;
      end
      if (beat) begin
        out_valid <= 1'b0;
      end
      if (accept) begin
        index_map[pos] <= nonzero;
        if (nonzero) begin
          out_data  <= in_data;
          out_pos   <= pos;
          out_valid <= 1'b1;
          nz_count  <= nz_count + CNT_W'(1);
        end
        // Hold at the final position rather than wrapping.
        if (!last) begin
          pos <= pos + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_vec_encoder.sv
// Directed testbench for sparse_vec_encoder with hand-computed expectations.
module tb_sparse_vec_encoder;

  localparam int unsigned DATA_W  = 9;
  localparam int unsigned VEC_LEN = 128;
  localparam int unsigned IDX_W   = 7;
  localparam int unsigned CNT_W   = 8;

  logic               clk;
  logic               reset;
  logic               start;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic [IDX_W-1:0]   out_pos;
  logic               out_ready;
  logic [VEC_LEN-1:0] index_map;
  logic [CNT_W-1:0]   nz_count;
  logic               busy;
  logic               done;

  int errors = 0;
  int checks = 0;

  logic signed [DATA_W-1:0] vec [VEC_LEN];

  sparse_vec_encoder #(
    .DATA_W(DATA_W), .VEC_LEN(VEC_LEN), .IDX_W(IDX_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_pos(out_pos), .out_ready(out_ready),
    .index_map(index_map), .nz_count(nz_count), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges and check every output is cleared.
  task automatic reset_and_check();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data",  128'(out_data),  128'(0));
    chk("rst_out_pos",   128'(out_pos),   128'(0));
    chk("rst_index_map", 128'(index_map), 128'(0));
    chk("rst_nz_count",  128'(nz_count),  128'(0));
    chk("rst_busy",      128'(busy),      128'(0));
    chk("rst_done",      128'(done),      128'(0));
    chk("rst_in_ready",  128'(in_ready),  128'(0));
    reset = 1'b0;
  endtask

  // Stream vec[] through the encoder with random stalls and check every beat.
  task automatic run_vector(input string name, input int vpct, input int rpct,
                            input bit hold_start, input bit chk_lat);
    logic [DATA_W-1:0]  exp_data [VEC_LEN];
    logic [IDX_W-1:0]   exp_pos  [VEC_LEN];
    logic [VEC_LEN-1:0] exp_map;
    int exp_n, idx, qh, n, last_acc;
    bit fin, nz_prev, stall_prev;
    logic ov;
    logic [DATA_W-1:0] od, prev_d;
    logic [IDX_W-1:0]  op, prev_p;

    exp_n = 0; exp_map = '0;
    for (int i = 0; i < int'(VEC_LEN); i++) begin
      if (vec[i] != 0) begin
        exp_data[exp_n] = vec[i];
        exp_pos[exp_n]  = IDX_W'(i);
        exp_map[i]      = 1'b1;
        exp_n++;
      end
    end

    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    if (!hold_start) start = 1'b0;
    chk({name, "_busy_start"}, 128'(busy), 128'(1));

    idx = 0; qh = 0; last_acc = 0; fin = 0; nz_prev = 0; stall_prev = 0;
    prev_d = '0; prev_p = '0;
    for (n = 0; n < 3000 && !fin; n++) begin
      ov = out_valid; od = out_data; op = out_pos;
      if (stall_prev) begin
        chk({name, "_stall_data"}, 128'(od), 128'(prev_d));
        chk({name, "_stall_pos"},  128'(op), 128'(prev_p));
      end
      if (nz_prev) chk({name, "_latency"}, 128'(ov), 128'(1));
      if (done) begin
        chk({name, "_index_map"}, 128'(index_map), 128'(exp_map));
        chk({name, "_nz_count"},  128'(nz_count),  128'(exp_n));
        chk({name, "_beats"},     128'(qh),        128'(exp_n));
        chk({name, "_all_in"},    128'(idx),       128'(VEC_LEN));
        chk({name, "_done_ov"},   128'(ov),        128'(0));
        if (chk_lat) chk({name, "_done_lat"}, 128'(n - last_acc), 128'(2));
        fin = 1;
      end else begin
        chk({name, "_busy"}, 128'(busy), 128'(1));
        out_ready = ($urandom_range(99) < 32'(rpct));
        in_valid  = (idx < int'(VEC_LEN)) && ($urandom_range(99) < 32'(vpct));
        in_data   = in_valid ? vec[idx] : DATA_W'($urandom);
        #1;
        chk({name, "_in_ready"}, 128'(in_ready),
            128'((idx < int'(VEC_LEN)) && (!ov || out_ready)));
        if (ov && out_ready) begin
          if (qh < exp_n) begin
            chk({name, "_beat_data"}, 128'(od), 128'(exp_data[qh]));
            chk({name, "_beat_pos"},  128'(op), 128'(exp_pos[qh]));
          end else begin
            chk({name, "_extra_beat"}, 128'(qh), 128'(exp_n - 1));
          end
          qh++;
        end
        nz_prev = 0;
        if (in_valid && in_ready) begin
          nz_prev  = (vec[idx] != 0);
          last_acc = n;
          idx++;
        end
        stall_prev = ov && !out_ready;
        prev_d = od; prev_p = op;
        @(negedge clk);
      end
    end
    if (!fin) chk({name, "_timeout"}, 128'(fin), 128'(1));
    in_valid = 1'b0;

    // Cycle after DONE: back in IDLE, single done pulse, results held.
    @(negedge clk);
    chk({name, "_done_once"}, 128'(done), 128'(0));
    chk({name, "_idle_busy"}, 128'(busy), 128'(0));
    chk({name, "_hold_map"},  128'(index_map), 128'(exp_map));
    chk({name, "_hold_cnt"},  128'(nz_count),  128'(exp_n));
    @(negedge clk);
    if (hold_start) begin
      chk({name, "_restart_busy"}, 128'(busy),      128'(1));
      chk({name, "_restart_map"},  128'(index_map), 128'(0));
      chk({name, "_restart_cnt"},  128'(nz_count),  128'(0));
    end else begin
      chk({name, "_stay_idle"}, 128'(busy),      128'(0));
      chk({name, "_hold_map2"}, 128'(index_map), 128'(exp_map));
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    reset_and_check();

    // Abort a vector after 50 accepted elements.
    for (int i = 0; i < int'(VEC_LEN); i++) vec[i] = DATA_W'(i + 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      in_data = vec[i];
      @(negedge clk);
    end
    chk("mid_nz_count", 128'(nz_count), 128'(50));
    reset_and_check();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_done", 128'(done), 128'(0));
    end

    // Dense 1..128 at full throughput.
    for (int i = 0; i < int'(VEC_LEN); i++) vec[i] = DATA_W'(i + 1);
    run_vector("dense", 100, 100, 1'b0, 1'b1);

    // All-zero vector.
    for (int i = 0; i < int'(VEC_LEN); i++) vec[i] = '0;
    run_vector("zero", 100, 100, 1'b0, 1'b0);
    chk("zero_map_const", 128'(index_map), 128'(0));

    // -3 at odd positions.
    for (int i = 0; i < int'(VEC_LEN); i++) vec[i] = (i % 2 == 1) ? -9'sd3 : 9'sd0;
    run_vector("odd", 100, 100, 1'b0, 1'b0);
    chk("odd_map_const", 128'(index_map), {32{4'hA}});
    chk("odd_cnt_const", 128'(nz_count),  128'(64));

    // Mixed values including the signed extremes, random stalls on both sides.
    for (int i = 0; i < int'(VEC_LEN); i++) begin
      if (i % 3 == 0)      vec[i] = 9'sd0;
      else if (i % 7 == 1) vec[i] = -9'sd256;
      else if (i % 5 == 2) vec[i] = 9'sd255;
      else                 vec[i] = DATA_W'(i - 64);
    end
    run_vector("stall", 60, 50, 1'b0, 1'b0);

    // start held high throughout: restart only after DONE returns to IDLE.
    run_vector("hold", 100, 70, 1'b1, 1'b0);
    reset_and_check();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
